// File: rtl/lb_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lb_bus_pkg
//  Purpose  : Shared FSM states, size/port encodings and beat helpers for the
//             local-bus sizer.
//  Revision : 1.0 - initial release
// ============================================================================
package lb_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    TERM  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [1:0] c_siz_long = 2'b00;
  localparam logic [1:0] c_siz_byte = 2'b01;
  localparam logic [1:0] c_siz_word = 2'b10;
  localparam logic [1:0] c_siz_line = 2'b11;

  localparam logic [1:0] c_port_32  = 2'b00;
  localparam logic [1:0] c_port_8   = 2'b01;
  localparam logic [1:0] c_port_16  = 2'b10;
  localparam logic [1:0] c_port_32x = 2'b11;

  // A line that is not burst-run is carried as a longword.
  function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
    case (siz)
      c_siz_byte: siz_bytes = 3'd1;
      c_siz_word: siz_bytes = 3'd2;
      default:    siz_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] beat_count(input logic [1:0] siz, input logic [1:0] port);
    logic [2:0] n_bytes;
    n_bytes = siz_bytes(siz);
    case (port)
      c_port_8:  beat_count = n_bytes;
      c_port_16: beat_count = (n_bytes + 3'd1) >> 1;
      default:   beat_count = 3'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lb_lane_steer.sv
`default_nettype none
// ============================================================================
//  Module   : lb_lane_steer
//  Purpose  : Byte-lane shifting between the CPU bus and a narrow target port.
//  Revision : 1.0 - initial release
// ============================================================================
module lb_lane_steer
  import lb_bus_pkg::*;
(
  input  logic [1:0]  i_port_size,
  input  logic [1:0]  i_beat_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [31:0] i_port_rdata,
  output logic [31:0] o_port_wdata,
  output logic [31:0] o_asm_data,
  output logic [31:0] o_asm_mask
);

  logic [31:0] w_port_mask;
  logic [4:0]  w_shift;

  // Narrow ports sit on the high lanes; the beat address selects which CPU
  // byte lanes they map to. A 32-bit port is lane-for-lane.
  always_comb begin
    w_port_mask = 32'hFFFF_FFFF;
    w_shift     = 5'd0;
    case (i_port_size)
      c_port_8: begin
        w_port_mask = 32'hFF00_0000;
        w_shift     = {i_beat_addr, 3'b000};
      end
      c_port_16: begin
        w_port_mask = 32'hFFFF_0000;
        w_shift     = {i_beat_addr, 3'b000};
      end
      default: ;
    endcase
  end

  assign o_port_wdata = (i_cpu_wdata << w_shift) & w_port_mask;
  assign o_asm_data   = (i_port_rdata & w_port_mask) >> w_shift;
  assign o_asm_mask   = w_port_mask >> w_shift;

endmodule
`default_nettype wire

// File: rtl/lb_bus_sizer.sv
`default_nettype none
// ============================================================================
//  Module   : lb_bus_sizer
//  Purpose  : Splits CPU transfers into beats sized for an 8/16/32-bit target
//             port and reassembles read data.
//  Revision : 1.0 - initial release
// ============================================================================
module lb_bus_sizer
  import lb_bus_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter int LINE_SPLIT = 1
) (
  input  logic        CLK40,
  input  logic        RESET,
  input  logic        TS_CPUn,
  input  logic        RnW,
  input  logic [1:0]  SIZ,
  input  logic [1:0]  A_040,
  input  logic [1:0]  PORTSIZE,
  input  logic        TACKn,
  input  logic        TEAn,
  input  logic [31:0] D_CPU_IN,
  output logic [31:0] D_CPU_OUT,
  output logic        D_CPU_OE,
  input  logic [31:0] D_PORT_IN,
  output logic [31:0] D_PORT_OUT,
  output logic        D_PORT_OE,
  output logic [1:0]  A_AMIGA,
  output logic        TSn,
  output logic        TAn,
  output logic        TEA_CPUn,
  output logic        TBI_CPUn,
  output logic        BUSY
);

  localparam logic [9:0] c_timeout = 10'(TIMEOUT);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_addr;
  logic [1:0]  r_siz;
  logic [1:0]  r_port;
  logic        r_rnw;
  logic [1:0]  r_beat;
  logic [9:0]  r_cnt;
  logic [31:0] r_asm;

  logic        w_burst;
  logic        w_last;
  logic        w_err;
  logic [2:0]  w_beats;
  logic [1:0]  w_offset;
  logic [1:0]  w_beat_addr;
  logic        w_active;
  logic [31:0] w_port_wdata;
  logic [31:0] w_asm_data;
  logic [31:0] w_asm_mask;

  always_comb begin
    w_burst  = (r_siz == c_siz_line) && (LINE_SPLIT == 0) && (r_port == c_port_32);
    w_beats  = w_burst ? 3'd4 : beat_count(r_siz, r_port);
    w_last   = ({1'b0, r_beat} == (w_beats - 3'd1));
    w_err    = !TEAn || (r_cnt == c_timeout);
    w_offset = 2'b00;
    case (r_port)
      c_port_8:  w_offset = r_beat;
      c_port_16: w_offset = {r_beat[0], 1'b0};
      default:   w_offset = 2'b00;
    endcase
    w_beat_addr = r_addr + w_offset;
    if (r_port == c_port_16) w_beat_addr[0] = 1'b0;
  end

  lb_lane_steer u_steer (
    .i_port_size  (r_port),
    .i_beat_addr  (w_beat_addr),
    .i_cpu_wdata  (D_CPU_IN),
    .i_port_rdata (D_PORT_IN),
    .o_port_wdata (w_port_wdata),
    .o_asm_data   (w_asm_data),
    .o_asm_mask   (w_asm_mask)
  );

  // Error (target or timeout) is checked ahead of the ack.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (!TS_CPUn) w_next = START;
      START: w_next = WAIT;
      WAIT: begin
        if (w_err)       w_next = ERR;
        else if (!TACKn) w_next = w_last ? TERM : NEXT;
      end
      NEXT:  w_next = START;
      TERM:  w_next = IDLE;
      ERR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      r_state <= IDLE;
      r_addr  <= 2'b00;
      r_siz   <= 2'b00;
      r_port  <= 2'b00;
      r_rnw   <= 1'b0;
      r_beat  <= 2'b00;
      r_cnt   <= 10'd0;
      r_asm   <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (!TS_CPUn) begin
            r_addr <= A_040;
            r_siz  <= SIZ;
            r_rnw  <= RnW;
            r_port <= (PORTSIZE == c_port_32x) ? c_port_32 : PORTSIZE;
            r_beat <= 2'b00;
            r_cnt  <= 10'd0;
            r_asm  <= 32'd0;
          end
        end
        WAIT: begin
          if (w_err) begin
            r_asm <= 32'd0;
          end else if (!TACKn) begin
            if (r_rnw) r_asm <= (r_asm & ~w_asm_mask) | (w_asm_data & w_asm_mask);
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        NEXT: begin
          r_beat <= r_beat + 2'd1;
          r_cnt  <= 10'd0;
        end
        default: ;
      endcase
    end
  end

  assign w_active   = (r_state == START) || (r_state == WAIT);
  assign BUSY       = (r_state != IDLE);
  assign TSn        = (r_state != START);
  assign A_AMIGA    = w_active ? w_beat_addr : 2'b00;
  assign D_PORT_OE  = w_active && !r_rnw;
  assign D_PORT_OUT = D_PORT_OE ? w_port_wdata : 32'd0;
  // Burst lines hand each beat to the CPU as it completes.
  assign TAn        = !((r_state == TERM) || ((r_state == NEXT) && w_burst));
  assign D_CPU_OE   = r_rnw && ((r_state == TERM) || ((r_state == NEXT) && w_burst));
  assign D_CPU_OUT  = r_asm;
  assign TEA_CPUn   = (r_state != ERR);
  assign TBI_CPUn   = !((r_state == TERM) && (r_siz == c_siz_line) && !w_burst);

endmodule
`default_nettype wire

// File: tb/tb_lb_bus_sizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lb_bus_sizer
//  Purpose  : Directed self-checking bench for lb_bus_sizer (TIMEOUT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lb_bus_sizer;

  logic        CLK40 = 1'b0;
  logic        RESET, TS_CPUn, RnW, TACKn, TEAn;
  logic [1:0]  SIZ, A_040, PORTSIZE, A_AMIGA;
  logic [31:0] D_CPU_IN, D_CPU_OUT, D_PORT_IN, D_PORT_OUT;
  logic        D_CPU_OE, D_PORT_OE, TSn, TAn, TEA_CPUn, TBI_CPUn, BUSY;

  int n_vec = 0;
  int n_err = 0;
  int ta_cnt = 0, tea_cnt = 0, tbi_cnt = 0;
  int ta0, tea0, tbi0;
  int k_hit;

  lb_bus_sizer #(.TIMEOUT(4), .LINE_SPLIT(1)) dut (
    .CLK40      (CLK40),
    .RESET      (RESET),
    .TS_CPUn    (TS_CPUn),
    .RnW        (RnW),
    .SIZ        (SIZ),
    .A_040      (A_040),
    .PORTSIZE   (PORTSIZE),
    .TACKn      (TACKn),
    .TEAn       (TEAn),
    .D_CPU_IN   (D_CPU_IN),
    .D_CPU_OUT  (D_CPU_OUT),
    .D_CPU_OE   (D_CPU_OE),
    .D_PORT_IN  (D_PORT_IN),
    .D_PORT_OUT (D_PORT_OUT),
    .D_PORT_OE  (D_PORT_OE),
    .A_AMIGA    (A_AMIGA),
    .TSn        (TSn),
    .TAn        (TAn),
    .TEA_CPUn   (TEA_CPUn),
    .TBI_CPUn   (TBI_CPUn),
    .BUSY       (BUSY)
  );

  always #5 CLK40 = ~CLK40;

  // Strobe pulse counters, sampled mid-cycle.
  always @(negedge CLK40) begin
    if (!TAn)      ta_cnt++;
    if (!TEA_CPUn) tea_cnt++;
    if (!TBI_CPUn) tbi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK40);
    #1;
  endtask

  function automatic logic [31:0] ctl();
    return {25'd0, TSn, TAn, TEA_CPUn, TBI_CPUn, D_CPU_OE, D_PORT_OE, BUSY};
  endfunction

  // Issue TS_CPUn for one cycle; returns with the DUT in START.
  task automatic start(input logic [1:0] a, input logic [1:0] siz, input logic rnw,
                       input logic [1:0] ps, input logic [31:0] wdata);
    A_040 = a; SIZ = siz; RnW = rnw; PORTSIZE = ps; D_CPU_IN = wdata;
    ta0 = ta_cnt; tea0 = tea_cnt; tbi0 = tbi_cnt;
    TS_CPUn = 1'b0;
    tick();
    TS_CPUn = 1'b1;
  endtask

  // From START: check beat address, ack in WAIT; ends in START (more) or TERM.
  task automatic beat(input string tag, input logic [1:0] exp_addr,
                      input logic [31:0] pdata, input logic last);
    check(tag, {30'd0, A_AMIGA}, {30'd0, exp_addr});
    TACKn = 1'b0; D_PORT_IN = pdata;
    tick();
    tick();
    TACKn = 1'b1;
    if (!last) tick();
  endtask

  initial begin
    RESET = 1'b1; TS_CPUn = 1'b1; RnW = 1'b1; SIZ = 2'b00; A_040 = 2'b00;
    PORTSIZE = 2'b00; TACKn = 1'b1; TEAn = 1'b1; D_CPU_IN = '0; D_PORT_IN = '0;
    repeat (3) tick();
    check("rst_ctl",   ctl(), 32'h78);
    check("rst_addr",  {30'd0, A_AMIGA}, 32'h0);
    check("rst_dcpu",  D_CPU_OUT, 32'h0);
    check("rst_dport", D_PORT_OUT, 32'h0);
    RESET = 1'b0;
    tick();

    // 32-bit long read, ack on first WAIT; TS held into START must be ignored
    A_040 = 2'd0; SIZ = 2'b00; RnW = 1'b1; PORTSIZE = 2'b00;
    TS_CPUn = 1'b0;
    tick();
    check("lat_start", ctl(), 32'h39);
    TACKn = 1'b0; D_PORT_IN = 32'hCAFE_F00D;
    tick();
    TS_CPUn = 1'b1;
    check("lat_wait_ta", {31'd0, TAn}, 32'h1);
    tick();
    check("lat_term_ta", {31'd0, TAn}, 32'h0);
    check("lat_data",    D_CPU_OUT, 32'hCAFE_F00D);
    check("lat_oe",      {31'd0, D_CPU_OE}, 32'h1);
    TACKn = 1'b1;
    tick();
    check("lat_idle", {31'd0, BUSY}, 32'h0);
    tick();
    check("ts_ignored", {31'd0, BUSY}, 32'h0);

    // long read on 8-bit port, A=0
    start(2'd0, 2'b00, 1'b1, 2'b01, 32'h0);
    beat("rd8_a0", 2'd0, 32'h1100_0000, 1'b0);
    beat("rd8_a1", 2'd1, 32'h2200_0000, 1'b0);
    beat("rd8_a2", 2'd2, 32'h3300_0000, 1'b0);
    beat("rd8_a3", 2'd3, 32'h4400_0000, 1'b1);
    check("rd8_data", D_CPU_OUT, 32'h1122_3344);
    tick();
    check("rd8_ta_cnt", ta_cnt - ta0, 32'd1);

    // word write 0xABCD at A=2, 16-bit port
    start(2'd2, 2'b10, 1'b0, 2'b10, 32'h0000_ABCD);
    check("wr16_dport", D_PORT_OUT, 32'hABCD_0000);
    check("wr16_oe",    {31'd0, D_PORT_OE}, 32'h1);
    beat("wr16_a", 2'd2, 32'h0, 1'b1);
    check("wr16_term_oe", {31'd0, D_PORT_OE}, 32'h0);
    tick();
    check("wr16_ta_cnt", ta_cnt - ta0, 32'd1);

    // word read at A=3 on 8-bit port wraps to address 0
    start(2'd3, 2'b10, 1'b1, 2'b01, 32'h0);
    beat("wrap_a3", 2'd3, 32'h5A00_0000, 1'b0);
    beat("wrap_a0", 2'd0, 32'hA500_0000, 1'b1);
    check("wrap_data", D_CPU_OUT, 32'hA500_005A);
    tick();
    check("wrap_tea_cnt", tea_cnt - tea0, 32'd0);

    // line read on 16-bit port: 2 beats, TAn with TBI_CPUn
    start(2'd0, 2'b11, 1'b1, 2'b10, 32'h0);
    beat("line_a0", 2'd0, 32'h1234_0000, 1'b0);
    beat("line_a2", 2'd2, 32'h5678_0000, 1'b1);
    check("line_data", D_CPU_OUT, 32'h1234_5678);
    check("line_tbi",  {31'd0, TBI_CPUn}, 32'h0);
    tick();
    check("line_ta_cnt",  ta_cnt - ta0, 32'd1);
    check("line_tbi_cnt", tbi_cnt - tbi0, 32'd1);

    // same line, TEAn and TACKn together on beat 1
    start(2'd0, 2'b11, 1'b1, 2'b10, 32'h0);
    beat("lerr_a0", 2'd0, 32'h1234_0000, 1'b0);
    check("lerr_a2", {30'd0, A_AMIGA}, 32'h2);
    TACKn = 1'b0; TEAn = 1'b0;
    tick();
    tick();
    TACKn = 1'b1; TEAn = 1'b1;
    check("lerr_tea",  {31'd0, TEA_CPUn}, 32'h0);
    check("lerr_data", D_CPU_OUT, 32'h0);
    tick();
    check("lerr_ta_cnt",  ta_cnt - ta0, 32'd0);
    check("lerr_tea_cnt", tea_cnt - tea0, 32'd1);
    check("lerr_idle",    {31'd0, BUSY}, 32'h0);

    // no ack: counter reaches 4 on the 5th WAIT cycle, ERR follows
    start(2'd0, 2'b00, 1'b1, 2'b00, 32'h0);
    k_hit = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!TEA_CPUn) begin
        k_hit = k;
        break;
      end
    end
    check("tmo_cycles", k_hit, 32'd6);
    tick();
    check("tmo_idle",    {31'd0, BUSY}, 32'h0);
    check("tmo_ta_cnt",  ta_cnt - ta0, 32'd0);
    check("tmo_tea_cnt", tea_cnt - tea0, 32'd1);

    // reset in WAIT of a byte-port long write
    start(2'd0, 2'b00, 1'b0, 2'b01, 32'hDEAD_BEEF);
    check("rstw_dport", D_PORT_OUT, 32'hDE00_0000);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("rstw_ctl",   ctl(), 32'h78);
    check("rstw_addr",  {30'd0, A_AMIGA}, 32'h0);
    check("rstw_dport", D_PORT_OUT, 32'h0);
    check("rstw_pulse", (ta_cnt - ta0) + (tea_cnt - tea0), 32'd0);
    start(2'd0, 2'b00, 1'b0, 2'b00, 32'h0102_0304);
    check("post_dport", D_PORT_OUT, 32'h0102_0304);
    beat("post_a", 2'd0, 32'h0, 1'b1);
    check("post_ta", {31'd0, TAn}, 32'h0);
    tick();
    check("post_idle", {31'd0, BUSY}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
